// File: rtl/dmem_responder.sv
// dmem_responder: target end of the core's load/store request/response
// interface. Accepts one word-aligned access at a time, waits LATENCY cycles,
// then presents the response and holds it until the core consumes it.
// The word array also serves as a small synthesizable scratch RAM.
module dmem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] txn_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  // BUSY counts down from LATENCY-2 so that the response is seen by the core
  // on the LATENCY-th edge after acceptance; LATENCY==1 skips BUSY entirely.
  localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_next;
  logic [3:0] cnt;
  logic [3:0] cnt_next;

  // Latched request: only the word index and the misalignment flag of the
  // address are kept, the rest of the address never affects the access.
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_idx;
  logic                  lat_mis;
  logic [31:0]           lat_wdata;
  logic [3:0]            lat_be;

  logic accept;
  logic enter_resp;
  logic leave_resp;

  // Operation performed on the edge that enters RESP.
  logic                  op_we;
  logic                  op_mis;
  logic [ADDR_WIDTH-1:0] op_idx;
  logic [31:0]           op_wdata;
  logic [3:0]            op_be;

  logic [ADDR_WIDTH-1:0] req_idx;
  logic                  req_mis;

  logic [31:0] mem [DEPTH];

  logic [31:0] rdata_q;
  logic        err_q;
  logic [15:0] count_q;

  // Upper address bits are deliberately ignored so accesses alias.
  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  assign req_idx = req_addr[ADDR_WIDTH+1:2];
  assign req_mis = |req_addr[1:0];

  assign req_ready = (state == IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign txn_count = count_q;

  // Select the request being committed: with LATENCY==1 RESP is entered on
  // the accept edge itself, so the live request must be used directly.
  always_comb begin
    op_we    = lat_we;
    op_mis   = lat_mis;
    op_idx   = lat_idx;
    op_wdata = lat_wdata;
    op_be    = lat_be;
    if (state == IDLE) begin
      op_we    = req_we;
      op_mis   = req_mis;
      op_idx   = req_idx;
      op_wdata = req_wdata;
      op_be    = req_be;
    end
  end

  // Next-state logic for the IDLE -> BUSY -> RESP handshake sequence.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    enter_resp = 1'b0;
    leave_resp = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_next = RESP;
            enter_resp = 1'b1;
          end else begin
            state_next = BUSY;
            cnt_next   = CNT_LOAD;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
          leave_resp = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register, latency counter and request latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_mis   <= 1'b0;
      lat_wdata <= 32'd0;
      lat_be    <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        lat_we    <= req_we;
        lat_idx   <= req_idx;
        lat_mis   <= req_mis;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
      end
    end
  end

  // Word array: byte-lane store on entry to RESP; never reset.
  always_ff @(posedge clk) begin
    if (enter_resp && op_we && !op_mis) begin
      for (int i = 0; i < 4; i++) begin
        if (op_be[i]) begin
          mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
        end
      end
    end
  end

  // Response data/error: captured on entry to RESP, held through stalls,
  // cleared once the core takes the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (enter_resp) begin
      err_q   <= op_mis;
      rdata_q <= (!op_we && !op_mis) ? mem[op_idx] : 32'd0;
    end else if (leave_resp) begin
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end
  end

  // Completed-response counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 16'd0;
    end else if (leave_resp) begin
      count_q <= count_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: directed vector table, stall/intrusion and
// mid-transaction reset sequences, then random traffic against a word-array
// reference model.
module tb_dmem_responder;

  localparam int AW      = 8;
  localparam int LAT     = 2;
  localparam int WORDS   = 1 << AW;
  localparam int TIMEOUT = 40;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [15:0] txn_count;

  int checks;
  int errors;
  int exp_count;

  logic [31:0] model_mem [WORDS];

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [16];

  dmem_responder #(
    .ADDR_WIDTH(AW),
    .LATENCY   (LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_be   (req_be),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .txn_count(txn_count)
  );

  // Clock starts high so negedges fall on 5, 15, 25 ns and posedges on 10, 20 ...
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Reference model: memory of WORDS words, index = (addr/4) mod WORDS.
  function automatic void model_txn(input logic we, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] be,
                                    output logic [31:0] rdata, output logic err);
    int          idx;
    logic [31:0] word;
    idx   = int'((addr / 4) % WORDS);
    rdata = 32'd0;
    err   = 1'b0;
    if (addr % 4 != 0) begin
      err = 1'b1;
      return;
    end
    if (we) begin
      word = model_mem[idx];
      for (int i = 0; i < 4; i++) begin
        if (be[i]) begin
          word = (word & ~(32'hFF << (8 * i))) | (wdata & (32'hFF << (8 * i)));
        end
      end
      model_mem[idx] = word;
    end else begin
      rdata = model_mem[idx];
    end
  endfunction

  // One complete transaction. Called away from a rising edge with the DUT
  // idle. Optionally stalls the response and pokes a rival request into it.
  task automatic applyStimulus(input string tag, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic [31:0] exp_rdata, input logic exp_err,
                               input int stall, input bit intrude);
    int lat;
    checkOutput({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_wdata = $urandom;
    lat = 1;
    while (!rsp_valid && lat < TIMEOUT) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, 32'(lat), 32'(LAT));
    checkOutput({tag, "_rdata"}, rsp_rdata, exp_rdata);
    checkOutput({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    for (int s = 0; s < stall; s++) begin
      if (intrude && s == 1) begin
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h50;
        req_wdata = 32'hBAD0BAD0;
        req_be    = 4'hF;
      end else begin
        req_valid = 1'b0;
      end
      @(negedge clk);
      checkOutput({tag, "_stall_valid"}, {31'd0, rsp_valid}, 32'd1);
      checkOutput({tag, "_stall_rdata"}, rsp_rdata, exp_rdata);
      checkOutput({tag, "_stall_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      checkOutput({tag, "_stall_ready"}, {31'd0, req_ready}, 32'd0);
      checkOutput({tag, "_stall_count"}, {16'd0, txn_count}, 32'(exp_count));
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_count = (exp_count + 1) % 65536;
    checkOutput({tag, "_post_valid"}, {31'd0, rsp_valid}, 32'd0);
    checkOutput({tag, "_post_rdata"}, rsp_rdata, 32'd0);
    checkOutput({tag, "_post_err"}, {31'd0, rsp_err}, 32'd0);
    checkOutput({tag, "_txn_count"}, {16'd0, txn_count}, 32'(exp_count));
  endtask

  initial begin
    logic [31:0] e_rdata;
    logic        e_err;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;

    checks    = 0;
    errors    = 0;
    exp_count = 0;

    vecs[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0};
    vecs[1]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h20,   32'h11223344, 4'hF, 32'h0,        1'b0};
    vecs[3]  = '{1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'h20,   32'h0,        4'h3, 32'h11BB33DD, 1'b0};
    vecs[5]  = '{1'b0, 32'h22,   32'h0,        4'hF, 32'h0,        1'b1};
    vecs[6]  = '{1'b0, 32'h20,   32'h0,        4'h0, 32'h11BB33DD, 1'b0};
    vecs[7]  = '{1'b1, 32'h13,   32'hFFFFFFFF, 4'hF, 32'h0,        1'b1};
    vecs[8]  = '{1'b0, 32'h10,   32'h0,        4'h0, 32'hDEADBEEF, 1'b0};
    vecs[9]  = '{1'b1, 32'h400,  32'hCAFEF00D, 4'hF, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'h000,  32'h0,        4'h0, 32'hCAFEF00D, 1'b0};
    vecs[11] = '{1'b1, 32'h30,   32'h00000000, 4'hF, 32'h0,        1'b0};
    vecs[12] = '{1'b1, 32'h30,   32'h12345678, 4'h0, 32'h0,        1'b0};
    vecs[13] = '{1'b0, 32'h30,   32'h0,        4'h0, 32'h00000000, 1'b0};
    vecs[14] = '{1'b1, 32'h50,   32'h600DF00D, 4'hF, 32'h0,        1'b0};
    vecs[15] = '{1'b0, 32'h1050, 32'h0,        4'h0, 32'h600DF00D, 1'b0};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 32'd0;
    req_wdata = 32'd0;
    req_be    = 4'd0;
    rsp_ready = 1'b0;

    #1;
    checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst_rdata", rsp_rdata, 32'd0);
    checkOutput("rst_err", {31'd0, rsp_err}, 32'd0);
    checkOutput("rst_count", {16'd0, txn_count}, 32'd0);
    #24;
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_req_ready", {31'd0, req_ready}, 32'd1);
    checkOutput("idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("idle_count", {16'd0, txn_count}, 32'd0);
    @(negedge clk);

    $display("[TB] directed vector table");
    for (int v = 0; v < 16; v++) begin
      applyStimulus($sformatf("vec%0d", v), vecs[v].we, vecs[v].addr, vecs[v].wdata,
                    vecs[v].be, vecs[v].exp_rdata, vecs[v].exp_err, 0, 1'b0);
    end

    $display("[TB] response stall with rival request");
    applyStimulus("stall_ld", 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 5, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("no_phantom_valid", {31'd0, rsp_valid}, 32'd0);
    end
    applyStimulus("rival_dropped", 1'b0, 32'h50, 32'h0, 4'h0, 32'h600DF00D, 1'b0, 0, 1'b0);
    applyStimulus("stall_mis", 1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1, 3, 1'b0);

    $display("[TB] reset during BUSY");
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h30;
    req_wdata = 32'h55555555;
    req_be    = 4'hF;
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_valid = 1'b0;
    exp_count = 0;
    #1;
    checkOutput("busy_rst_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("busy_rst_count", {16'd0, txn_count}, 32'd0);
    checkOutput("busy_rst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("busy_rst_hold_valid", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("busy_rel_ready", {31'd0, req_ready}, 32'd1);
    applyStimulus("busy_dropped", 1'b0, 32'h30, 32'h0, 4'h0, 32'h00000000, 1'b0, 0, 1'b0);

    $display("[TB] reset during RESP");
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'h40;
    req_wdata = 32'h77777777;
    req_be    = 4'hF;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    checkOutput("resp_before_rst", {31'd0, rsp_valid}, 32'd1);
    reset     = 1'b1;
    exp_count = 0;
    #1;
    checkOutput("resp_rst_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("resp_rst_rdata", rsp_rdata, 32'd0);
    checkOutput("resp_rst_count", {16'd0, txn_count}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    applyStimulus("resp_kept", 1'b0, 32'h40, 32'h0, 4'h0, 32'h77777777, 1'b0, 0, 1'b0);

    $display("[TB] random traffic against reference model");
    for (int w = 0; w < WORDS; w++) begin
      r_wdata = $urandom;
      r_addr  = 32'(w * 4);
      model_txn(1'b1, r_addr, r_wdata, 4'hF, e_rdata, e_err);
      applyStimulus("init", 1'b1, r_addr, r_wdata, 4'hF, e_rdata, e_err, 0, 1'b0);
    end
    for (int n = 0; n < 300; n++) begin
      r_we    = 1'($urandom_range(0, 1));
      r_addr  = $urandom;
      if ($urandom_range(0, 7) != 0) r_addr[1:0] = 2'b00;
      r_wdata = $urandom;
      r_be    = 4'($urandom_range(0, 15));
      model_txn(r_we, r_addr, r_wdata, r_be, e_rdata, e_err);
      applyStimulus($sformatf("rnd%0d", n), r_we, r_addr, r_wdata, r_be, e_rdata, e_err,
                    $urandom_range(0, 3), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
